// File: rtl/mult_share_ctrl.sv
// Round-robin shared Q(BITS) multiply-dequantize unit for NUM_REQ requesters, one operation in flight.
// Build option MULT_SHARE_SAT_EN: full-width product with saturation and a sticky sat_flag output.
module mult_share_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int BITS       = 10
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_x,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_y,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy
`ifdef MULT_SHARE_SAT_EN
    ,
    output logic                          sat_flag
`endif
);

    // state | meaning
    // IDLE  | scan requests from rr_ptr, grant first valid, latch operands
    // MUL   | compute product and dequantize, register result
    // RESP  | present result to owner until its rsp_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW  = IDW + 1;

    state_t                       state, state_nxt;
    logic [IDW-1:0]               rr_ptr, id_q, grant_id;
    logic                         grant_found;
    logic [SW-1:0]                scan_idx;
    logic [DATA_WIDTH-1:0]        x_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]        y_arr [NUM_REQ];
    logic signed [DATA_WIDTH-1:0] x_q, y_q, res;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            x_arr[i] = req_x[i*DATA_WIDTH +: DATA_WIDTH];
            y_arr[i] = req_y[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + SW'(k);
            if (scan_idx >= SW'(NUM_REQ))
                scan_idx = scan_idx - SW'(NUM_REQ);
            if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx[IDW-1:0];
            end
        end
    end

    // Bias negative products by 2^BITS-1 so the arithmetic shift truncates toward zero.
`ifdef MULT_SHARE_SAT_EN
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic signed [PW-1:0] BIAS    = {{(PW-BITS){1'b0}}, {BITS{1'b1}}};
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [PW-1:0] prod, prod_adj, quot;
    logic                 res_sat;

    always_comb begin
        prod     = $signed({{DATA_WIDTH{x_q[DATA_WIDTH-1]}}, x_q}) *
                   $signed({{DATA_WIDTH{y_q[DATA_WIDTH-1]}}, y_q});
        prod_adj = prod[PW-1] ? prod + BIAS : prod;
        quot     = prod_adj >>> BITS;
        res_sat  = 1'b0;
        res      = quot[DATA_WIDTH-1:0];
        if (quot > SAT_MAX) begin
            res     = SAT_MAX[DATA_WIDTH-1:0];
            res_sat = 1'b1;
        end else if (quot < SAT_MIN) begin
            res     = SAT_MIN[DATA_WIDTH-1:0];
            res_sat = 1'b1;
        end
    end
`else
    localparam logic signed [DATA_WIDTH-1:0] BIAS = {{(DATA_WIDTH-BITS){1'b0}}, {BITS{1'b1}}};

    logic signed [DATA_WIDTH-1:0] prod, prod_adj;

    always_comb begin
        prod     = x_q * y_q;
        prod_adj = prod[DATA_WIDTH-1] ? prod + BIAS : prod;
        res      = prod_adj >>> BITS;
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        case (state)
            IDLE: begin
                if (reset_n && grant_found) begin
                    req_ready[grant_id] = 1'b1;
                    state_nxt           = MUL;
                end
            end
            MUL:  state_nxt = RESP;
            RESP: begin
                rsp_valid[id_q] = 1'b1;
                if (rsp_ready[id_q])
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_q      <= '0;
            y_q      <= '0;
            id_q     <= '0;
            rr_ptr   <= '0;
            rsp_data <= '0;
`ifdef MULT_SHARE_SAT_EN
            sat_flag <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        x_q  <= x_arr[grant_id];
                        y_q  <= y_arr[grant_id];
                        id_q <= grant_id;
                    end
                end
                MUL: begin
                    rsp_data <= res;
`ifdef MULT_SHARE_SAT_EN
                    sat_flag <= sat_flag | res_sat;
`endif
                end
                RESP: begin
                    if (rsp_ready[id_q])
                        rr_ptr <= (id_q == IDW'(NUM_REQ-1)) ? '0 : id_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed plus random bench for mult_share_ctrl against an arithmetic reference model.
module tb_mult_share_ctrl;
    localparam int DW   = 32;
    localparam int NR   = 4;
    localparam int BITS = 10;
    localparam longint DIV  = 64'sd1 << BITS;
    localparam longint QMAX = 64'sd2147483647;
    localparam longint QMIN = -64'sd2147483648;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NR*DW-1:0]  req_x, req_y;
    logic [DW-1:0]     rsp_data;
    logic              busy;
`ifdef MULT_SHARE_SAT_EN
    logic              sat_flag;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [31:0] tx [NR];
    logic [31:0] ty [NR];
    int          rr_model;
    bit          sat_seen;

    always #5 clock = ~clock;

    mult_share_ctrl #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BITS(BITS)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef MULT_SHARE_SAT_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Exact rational meaning of the operation: product / 2^BITS, truncated toward zero.
    function automatic logic [31:0] ref_res(input logic [31:0] x, input logic [31:0] y, output bit sat);
        longint p, q;
        int     pw;
        p   = longint'($signed(x)) * longint'($signed(y));
        sat = 1'b0;
`ifdef MULT_SHARE_SAT_EN
        pw = 0;
        q  = p / DIV;
        if (q > QMAX) begin q = QMAX; sat = 1'b1; end
        else if (q < QMIN) begin q = QMIN; sat = 1'b1; end
`else
        pw = int'(p);
        q  = longint'(pw) / DIV;
`endif
        return 32'(q);
    endfunction

    function automatic int pick(input logic [NR-1:0] m);
        for (int k = 0; k < NR; k++)
            if (m[(rr_model + k) % NR]) return (rr_model + k) % NR;
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < NR; i++) begin
            req_x[i*DW +: DW] = tx[i];
            req_y[i*DW +: DW] = ty[i];
        end
    endtask

    task automatic check_sat();
`ifdef MULT_SHARE_SAT_EN
        chk("sat_flag", {63'd0, sat_flag}, {63'd0, sat_seen});
`endif
    endtask

    // Entered in IDLE just after a falling edge with req_valid/operands already driven.
    task automatic arb_op(input int hold, input bit drop);
        int            g;
        logic [NR-1:0] oh;
        logic [31:0]   e;
        bit            s;
        #1;
        g  = pick(req_valid);
        oh = '0;
        if (g >= 0) oh[g] = 1'b1;
        e = ref_res(tx[(g >= 0) ? g : 0], ty[(g >= 0) ? g : 0], s);
        chk("grant", 64'(req_ready), 64'(oh));
        chk("idle_busy", {63'd0, busy}, 64'd0);
        @(negedge clock); #1;
        chk("mul_ready", 64'(req_ready), 64'd0);
        chk("mul_valid", 64'(rsp_valid), 64'd0);
        chk("mul_busy", {63'd0, busy}, 64'd1);
        if (drop) begin
            req_valid = '0;
            for (int i = 0; i < NR; i++) begin
                req_x[i*DW +: DW] = $urandom;
                req_y[i*DW +: DW] = $urandom;
            end
        end
        rsp_ready = (hold == 0) ? '1 : ~oh;
        for (int h = 0; h <= hold; h++) begin
            @(negedge clock); #1;
            chk("resp_valid", 64'(rsp_valid), 64'(oh));
            chk("resp_data", 64'(rsp_data), 64'(e));
            chk("resp_ready", 64'(req_ready), 64'd0);
            if (h == hold) rsp_ready = '1;
        end
        if (s) sat_seen = 1'b1;
        @(negedge clock); #1;
        chk("done_valid", 64'(rsp_valid), 64'd0);
        chk("done_busy", {63'd0, busy}, 64'd0);
        if (g >= 0) rr_model = (g + 1) % NR;
        check_sat();
    endtask

    task automatic single_op(input int idx, input logic [31:0] x, input logic [31:0] y);
        tx[idx] = x;
        ty[idx] = y;
        drive_ops();
        req_valid = '0;
        req_valid[idx] = 1'b1;
        arb_op(0, 1'b1);
    endtask

    task automatic reset_model();
        rr_model = 0;
        sat_seen = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        reset_n   = 1'b0;
        req_valid = '1;
        rsp_ready = '0;
        req_x     = '0;
        req_y     = '0;
        for (int i = 0; i < NR; i++) begin tx[i] = 0; ty[i] = 0; end
        reset_model();
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        check_sat();
        req_valid = '0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        single_op(1, 32'd1536, 32'd2048);
        single_op(0, -32'sd1536, 32'd2048);
        single_op(2, 32'hFFFF_FFFF, 32'd1);
        single_op(3, 32'd1, 32'd1023);
        single_op(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        single_op(2, 32'h8000_0000, 32'h7FFF_FFFF);

        for (int n = 0; n < 16; n++) begin
            idx = int'($urandom_range(0, NR-1));
            if (n[0])
                single_op(idx, $urandom, $urandom);
            else
                single_op(idx, 32'(int'($urandom_range(0, 65535)) - 32768),
                               32'(int'($urandom_range(0, 65535)) - 32768));
        end

        @(negedge clock); #1;
        chk("noreq_ready", 64'(req_ready), 64'd0);
        chk("noreq_busy", {63'd0, busy}, 64'd0);

        reset_n = 1'b0;
        reset_model();
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < NR; i++) begin tx[i] = $urandom; ty[i] = $urandom_range(0, 4095); end
        drive_ops();
        req_valid = '1;
        for (int n = 0; n < 6; n++) arb_op(0, 1'b0);

        req_valid = 4'b1101;
        arb_op(5, 1'b0);
        arb_op(0, 1'b0);
        arb_op(0, 1'b0);
        req_valid = '0;

        req_valid = 4'b1000;
        #1;
        @(negedge clock); #1;
        chk("mid_mul_busy", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mul_valid", 64'(rsp_valid), 64'd0);
        chk("rst_mul_busy", {63'd0, busy}, 64'd0);
        chk("rst_mul_ready", 64'(req_ready), 64'd0);
        reset_model();
        @(negedge clock);
        reset_n   = 1'b1;
        req_valid = 4'b1010;
        arb_op(0, 1'b1);

        req_valid = 4'b0100;
        rsp_ready = '0;
        #1;
        @(negedge clock);
        @(negedge clock); #1;
        chk("mid_resp_valid", 64'(rsp_valid), 64'b0100);
        reset_n = 1'b0;
        #1;
        chk("rst_resp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_resp_busy", {63'd0, busy}, 64'd0);
        chk("rst_resp_data", 64'(rsp_data), 64'd0);
        reset_model();
        check_sat();
        req_valid = '0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock); #1;
        chk("post_rst_valid", 64'(rsp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
